// File: rtl/osc_feed.sv
// Note oscillator feeding the sequential divider: phase count, period divisor and sample pulse.
// Captures the divider quotient on done and presents it as the sawtooth sample.
module osc_feed #(
    parameter int unsigned SAMPLE_DIV = 256,
    parameter int unsigned CNT_W      = 19
) (
    input  logic             clk,
    input  logic             RST,
    input  logic [3:0]       note_sel,
    input  logic [2:0]       octave,
    input  logic             note_en,
    input  logic             done,
    input  logic [7:0]       q_in,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] dsor,
    output logic             sample,
    output logic [7:0]       wave_out,
    output logic             overrun
);

    localparam int unsigned TICK_W = $clog2(SAMPLE_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_DIV - 1);
    localparam logic [6:0] PEND_REST = {4'd12, 3'd0};

    typedef enum logic {StRest, StPlay} state_t;

    state_t            state;
    logic [TICK_W-1:0] tick;
    logic              busy;
    logic              done_q;
    logic [6:0]        pending;
    logic              pend_note;
    logic              done_rise;
    logic              wrap;

    function automatic logic [CNT_W-1:0] base_period(input logic [3:0] idx);
        logic [CNT_W-1:0] v;
        v = '0;
        unique case (idx)
            4'd0:    v = CNT_W'(38222);
            4'd1:    v = CNT_W'(36077);
            4'd2:    v = CNT_W'(34052);
            4'd3:    v = CNT_W'(32141);
            4'd4:    v = CNT_W'(30337);
            4'd5:    v = CNT_W'(28634);
            4'd6:    v = CNT_W'(27027);
            4'd7:    v = CNT_W'(25510);
            4'd8:    v = CNT_W'(24079);
            4'd9:    v = CNT_W'(22727);
            4'd10:   v = CNT_W'(21452);
            4'd11:   v = CNT_W'(20248);
            default: v = '0;
        endcase
        return v;
    endfunction

    // Clamp keeps the phase counter toggling 0,1 at extreme octave shifts.
    function automatic logic [CNT_W-1:0] period(input logic [6:0] p);
        logic [CNT_W-1:0] v;
        v = base_period(p[6:3]) >> p[2:0];
        if (v < CNT_W'(2)) begin
            v = CNT_W'(2);
        end
        return v;
    endfunction

    assign pend_note = (pending[6:3] < 4'd12);
    assign done_rise = done & ~done_q;
    assign wrap      = (count == dsor - CNT_W'(1));
    assign sample    = (state == StPlay) && (tick == TICK_LAST);

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state    <= StRest;
            count    <= '0;
            dsor     <= '0;
            tick     <= '0;
            busy     <= 1'b0;
            done_q   <= 1'b0;
            pending  <= PEND_REST;
            wave_out <= 8'h00;
            overrun  <= 1'b0;
        end else begin
            done_q <= done;
            if (note_en) begin
                pending <= {note_sel, octave};
            end
            unique case (state)
                StRest: begin
                    count    <= '0;
                    tick     <= '0;
                    busy     <= 1'b0;
                    wave_out <= 8'h00;
                    if (pend_note) begin
                        dsor  <= period(pending);
                        state <= StPlay;
                    end
                end
                StPlay: begin
                    tick <= (tick == TICK_LAST) ? '0 : tick + TICK_W'(1);
                    if (done_rise) begin
                        wave_out <= q_in;
                    end
                    // A done rise in the sample cycle means the previous division finished.
                    if (sample) begin
                        busy <= 1'b1;
                        if (busy && !done_rise) begin
                            overrun <= 1'b1;
                        end
                    end else if (done_rise) begin
                        busy <= 1'b0;
                    end
                    if (wrap) begin
                        count <= '0;
                        if (pend_note) begin
                            dsor <= period(pending);
                        end else begin
                            state    <= StRest;
                            tick     <= '0;
                            busy     <= 1'b0;
                            wave_out <= 8'h00;
                        end
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                default: state <= StRest;
            endcase
        end
    end

endmodule
